// File: rtl/sdm_dwa.sv
// sdm_dwa: data-weighted-averaging unit-element selector for the multibit sigma-delta DAC.
module sdm_dwa #(
    parameter int N      = 8,
    parameter int PW     = 3,
    parameter int OFFSET = 4
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [3:0]    sdm_in,
    input  logic          in_vld,
    input  logic          dwa_en,
    input  logic          ptr_clr,
    input  logic          ovf_clr,
    output logic [N-1:0]  sel_out,
    output logic          out_vld,
    output logic [PW-1:0] ptr,
    output logic          ovf
);
    logic signed [PW+1:0] k_raw;
    logic                 k_neg;
    logic                 k_big;
    logic [PW:0]          k;
    logic [PW-1:0]        p_eff;
    logic [N:0]           therm_ext;
    logic [N-1:0]         therm;
    logic [2*N-1:0]       rot;
    logic [N-1:0]         sel_nxt;
    logic [PW-1:0]        ptr_nxt;

    assign k_raw = $signed({{(PW-2){sdm_in[3]}}, sdm_in}) + $signed((PW+2)'(OFFSET));

    always_comb begin
        k_neg     = k_raw[PW+1];
        k_big     = k_raw > $signed((PW+2)'(N));
        k         = k_neg ? '0 : k_big ? (PW+1)'(N) : k_raw[PW:0];
        p_eff     = ptr_clr ? '0 : ptr;
        therm_ext = ((N+1)'(1) << k) - (N+1)'(1);
        therm     = therm_ext[N-1:0];
        // Doubling the thermometer word turns the left shift into a wrap-around rotate.
        rot       = {therm, therm} << p_eff;
        sel_nxt   = dwa_en ? rot[2*N-1:N] : therm;
        ptr_nxt   = dwa_en ? p_eff + k[PW-1:0] : '0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sel_out <= '0;
            out_vld <= 1'b0;
            ptr     <= '0;
            ovf     <= 1'b0;
        end else begin
            out_vld <= in_vld;
            ovf     <= (in_vld & k_big) | (ovf & ~ovf_clr);
            if (in_vld) begin
                sel_out <= sel_nxt;
                ptr     <= ptr_nxt;
            end else if (ptr_clr) begin
                ptr <= '0;
            end
        end
    end
endmodule

// File: tb/tb_sdm_dwa.sv
// tb_sdm_dwa: directed self-checking bench for the DWA element selector.
module tb_sdm_dwa;
    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [3:0] sdm_in = 4'h0;
    logic       in_vld = 1'b0;
    logic       dwa_en = 1'b0;
    logic       ptr_clr = 1'b0;
    logic       ovf_clr = 1'b0;
    logic [7:0] sel_out;
    logic       out_vld;
    logic [2:0] ptr;
    logic       ovf;
    int         checks = 0;
    int         errors = 0;

    sdm_dwa dut (
        .clk(clk), .rstn(rstn), .sdm_in(sdm_in), .in_vld(in_vld), .dwa_en(dwa_en),
        .ptr_clr(ptr_clr), .ovf_clr(ovf_clr), .sel_out(sel_out), .out_vld(out_vld),
        .ptr(ptr), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] s, input logic [2:0] p,
                           input logic v, input logic o);
        chk({tag, ".sel"}, 16'(sel_out), 16'(s));
        chk({tag, ".ptr"}, 16'(ptr), 16'(p));
        chk({tag, ".vld"}, 16'(out_vld), 16'(v));
        chk({tag, ".ovf"}, 16'(ovf), 16'(o));
    endtask

    initial begin
        repeat (2) tick();
        chk_all("reset", 8'h00, 3'd0, 1'b0, 1'b0);
        rstn = 1'b1;
        dwa_en = 1'b1;
        in_vld = 1'b1;
        sdm_in = 4'hF;
        tick(); chk_all("rot0", 8'h07, 3'd3, 1'b1, 1'b0);
        tick(); chk_all("rot1", 8'h38, 3'd6, 1'b1, 1'b0);
        tick(); chk_all("rot2", 8'hC1, 3'd1, 1'b1, 1'b0);
        tick(); chk_all("rot3", 8'h0E, 3'd4, 1'b1, 1'b0);
        sdm_in = 4'h4; tick(); chk_all("pos4", 8'hFF, 3'd4, 1'b1, 1'b0);
        sdm_in = 4'hC; tick(); chk_all("neg4", 8'h00, 3'd4, 1'b1, 1'b0);
        sdm_in = 4'h5; tick(); chk_all("pos5", 8'hFF, 3'd4, 1'b1, 1'b1);
        sdm_in = 4'hF; tick(); chk_all("sticky", 8'h70, 3'd7, 1'b1, 1'b1);
        sdm_in = 4'h5; ovf_clr = 1'b1; tick(); chk_all("setwins", 8'hFF, 3'd7, 1'b1, 1'b1);
        in_vld = 1'b0; tick(); chk_all("ovfclr", 8'hFF, 3'd7, 1'b0, 1'b0);
        ovf_clr = 1'b0; in_vld = 1'b1; sdm_in = 4'hB;
        tick(); chk_all("neg5", 8'h00, 3'd7, 1'b1, 1'b0);
        sdm_in = 4'h5; tick(); chk_all("preRst", 8'hFF, 3'd7, 1'b1, 1'b1);
        #2 rstn = 1'b0;
        #1 chk_all("asyncRst", 8'h00, 3'd0, 1'b0, 1'b0);
        tick(); chk_all("rstHeld", 8'h00, 3'd0, 1'b0, 1'b0);
        rstn = 1'b1; sdm_in = 4'hF;
        tick(); chk_all("postRst", 8'h07, 3'd3, 1'b1, 1'b0);
        sdm_in = 4'hE; tick(); chk_all("toPtr5", 8'h18, 3'd5, 1'b1, 1'b0);
        dwa_en = 1'b0; sdm_in = 4'h1;
        tick(); chk_all("therm0", 8'h1F, 3'd0, 1'b1, 1'b0);
        tick(); chk_all("therm1", 8'h1F, 3'd0, 1'b1, 1'b0);
        dwa_en = 1'b1; tick(); chk_all("dwa5", 8'h1F, 3'd5, 1'b1, 1'b0);
        ptr_clr = 1'b1; sdm_in = 4'hE;
        tick(); chk_all("clrCol", 8'h03, 3'd2, 1'b1, 1'b0);
        ptr_clr = 1'b0; in_vld = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(); chk_all("stall", 8'h03, 3'd2, 1'b0, 1'b0);
        end
        ptr_clr = 1'b1; tick(); chk_all("clrIdle", 8'h03, 3'd0, 1'b0, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
